commit_buffer: RTL and testbench

COMMIT_BUFFER -- requirements
Module: commit_buffer

---
 rtl/commit_buffer_if.sv | 35 +++
 rtl/commit_buffer.sv | 94 +++++++++
 tb/tb_commit_buffer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/commit_buffer_if.sv
// Dispatch/completion/commit bus between the pipeline and the in-order commit buffer.
// The master modport is the pipeline side; the slave modport is the buffer.
interface commit_buffer_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = $clog2(DEPTH)
);
    logic             alloc_valid_i;
    logic [4:0]       alloc_rd_i;
    logic             alloc_wb_i;
    logic             alloc_ready_o;
    logic [TAG_W-1:0] alloc_tag_o;
    logic             cmpl_valid_i;
    logic [TAG_W-1:0] cmpl_tag_i;
    logic [31:0]      cmpl_data_i;
    logic             flush_i;
    logic             wr_en_o;
    logic [4:0]       wr_addr_o;
    logic [31:0]      wr_data_o;
    logic [TAG_W:0]   count_o;
    logic             empty_o;

    modport master (
        output alloc_valid_i, alloc_rd_i, alloc_wb_i,
        output cmpl_valid_i, cmpl_tag_i, cmpl_data_i, flush_i,
        input  alloc_ready_o, alloc_tag_o,
        input  wr_en_o, wr_addr_o, wr_data_o, count_o, empty_o
    );

    modport slave (
        input  alloc_valid_i, alloc_rd_i, alloc_wb_i,
        input  cmpl_valid_i, cmpl_tag_i, cmpl_data_i, flush_i,
        output alloc_ready_o, alloc_tag_o,
        output wr_en_o, wr_addr_o, wr_data_o, count_o, empty_o
    );
endinterface

// File: rtl/commit_buffer.sv
// In-order commit buffer: entries are allocated in program order, completed out of order,
// and retired to the register file one per cycle from the head.
module commit_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = $clog2(DEPTH)
) (
    input logic clk_i,
    input logic rst_i,
    commit_buffer_if.slave bus
);
    localparam int unsigned PtrW = TAG_W + 1;

    logic [PtrW-1:0]  head_q, tail_q;
    logic [TAG_W-1:0] head_idx, tail_idx;
    logic [DEPTH-1:0] valid_q, done_q, wb_q;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic             wr_en_q;
    logic [4:0]       wr_addr_q;
    logic [31:0]      wr_data_q;

    logic full;
    logic alloc_fire, cmpl_fire, commit_fire;

    always_comb begin
        head_idx = head_q[TAG_W-1:0];
        tail_idx = tail_q[TAG_W-1:0];
        // Extra pointer bit disambiguates full from empty when the indices match.
        full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

        // Slot availability comes from pre-edge state, so a same-cycle commit never frees it.
        alloc_fire  = bus.alloc_valid_i && !full && !bus.flush_i;
        cmpl_fire   = bus.cmpl_valid_i && valid_q[bus.cmpl_tag_i] && !bus.flush_i;
        commit_fire = valid_q[head_idx] && done_q[head_idx];

        bus.alloc_ready_o = !full;
        bus.alloc_tag_o   = tail_idx;
        bus.count_o       = tail_q - head_q;
        bus.empty_o       = (tail_q == head_q);
        bus.wr_en_o       = wr_en_q;
        bus.wr_addr_o     = wr_addr_q;
        bus.wr_data_o     = wr_data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            done_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (bus.flush_i) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            wr_en_q <= 1'b0;
        end else begin
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                tail_q            <= tail_q + PtrW'(1);
            end
            if (cmpl_fire) begin
                done_q[bus.cmpl_tag_i] <= 1'b1;
            end
            // Commit is last so retiring the head wins over a repeat completion to it.
            if (commit_fire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                head_q            <= head_q + PtrW'(1);
                wr_en_q           <= wb_q[head_idx] && (rd_q[head_idx] != 5'd0);
                wr_addr_q         <= rd_q[head_idx];
                wr_data_q         <= data_q[head_idx];
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    // Payload needs no reset: it is only read while the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            rd_q[tail_idx] <= bus.alloc_rd_i;
            wb_q[tail_idx] <= bus.alloc_wb_i;
        end
        if (cmpl_fire) begin
            data_q[bus.cmpl_tag_i] <= bus.cmpl_data_i;
        end
    end
endmodule

// File: tb/tb_commit_buffer.sv
// Directed bench for commit_buffer; expected register-file writes go into a scoreboard queue
// that an independent monitor drains whenever wr_en_o is seen high.
module tb_commit_buffer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = 3;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;

    commit_buffer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    commit_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic alloc(input logic v, input logic [4:0] rd, input logic wb);
        bus.alloc_valid_i = v;
        bus.alloc_rd_i    = rd;
        bus.alloc_wb_i    = wb;
    endtask

    task automatic cmpl(input logic v, input logic [TAG_W-1:0] tag, input logic [31:0] data);
        bus.cmpl_valid_i = v;
        bus.cmpl_tag_i   = tag;
        bus.cmpl_data_i  = data;
    endtask

    // Scoreboard monitor: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (bus.wr_en_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         bus.wr_addr_o, bus.wr_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.wr_addr_o, bus.wr_data_o} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.wr_addr_o, bus.wr_data_o, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        alloc(1'b0, 5'd0, 1'b0);
        cmpl(1'b0, '0, '0);
        bus.flush_i = 1'b0;
        rst = 1'b1;
        #3;
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_empty", 32'(bus.empty_o), 32'd1);
        chk("rst_ready", 32'(bus.alloc_ready_o), 32'd1);
        chk("rst_tag", 32'(bus.alloc_tag_o), 32'd0);
        chk("rst_wr", {26'd0, bus.wr_en_o, bus.wr_addr_o}, 32'd0);
        chk("rst_wdata", bus.wr_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // In-order retire from out-of-order completions
        for (int i = 0; i < 3; i++) begin
            alloc(1'b1, 5'(i + 1), 1'b1);
            chk("inord_tag", 32'(bus.alloc_tag_o), 32'(i));
            step();
        end
        alloc(1'b0, 5'd0, 1'b0);
        chk("inord_count3", 32'(bus.count_o), 32'd3);
        expect_wr(5'd1, 32'h11);
        expect_wr(5'd2, 32'h22);
        expect_wr(5'd3, 32'h33);
        cmpl(1'b1, 3'd2, 32'h33); step();
        chk("inord_no_early", 32'(bus.wr_en_o), 32'd0);
        cmpl(1'b1, 3'd0, 32'h11); step();
        cmpl(1'b1, 3'd1, 32'h22); step();
        chk("latency_wr_en", 32'(bus.wr_en_o), 32'd1);
        cmpl(1'b0, '0, '0);
        step(); step(); step();
        chk("inord_count0", 32'(bus.count_o), 32'd0);
        chk("inord_wr_idle", 32'(bus.wr_en_o), 32'd0);
        chk("hold_addr", 32'(bus.wr_addr_o), 32'd3);
        chk("hold_data", bus.wr_data_o, 32'h33);

        // Full buffer, commit does not free a slot in its own cycle, tag wraps to 0
        bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
        chk("flush_tag0", 32'(bus.alloc_tag_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            alloc(1'b1, 5'(i + 8), 1'b1);
            chk("full_tag", 32'(bus.alloc_tag_o), 32'(i));
            step();
        end
        chk("full_ready", 32'(bus.alloc_ready_o), 32'd0);
        chk("full_count", 32'(bus.count_o), 32'd8);
        step();
        chk("full_no_alloc", 32'(bus.count_o), 32'd8);
        alloc(1'b0, 5'd0, 1'b0);
        expect_wr(5'd8, 32'hA0);
        cmpl(1'b1, 3'd0, 32'hA0); step();
        cmpl(1'b0, '0, '0);
        alloc(1'b1, 5'd20, 1'b1);
        chk("full_ready_pre", 32'(bus.alloc_ready_o), 32'd0);
        step();
        chk("full_after_commit", 32'(bus.count_o), 32'd7);
        chk("full_ready_post", 32'(bus.alloc_ready_o), 32'd1);
        chk("wrap_tag", 32'(bus.alloc_tag_o), 32'd0);
        step();
        alloc(1'b0, 5'd0, 1'b0);
        chk("wrap_count", 32'(bus.count_o), 32'd8);
        chk("wrap_next_tag", 32'(bus.alloc_tag_o), 32'd1);
        bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
        chk("flush_count", 32'(bus.count_o), 32'd0);

        // x0 and no-write instructions retire silently
        alloc(1'b1, 5'd0, 1'b1); step();
        alloc(1'b1, 5'd5, 1'b0); step();
        alloc(1'b0, 5'd0, 1'b0);
        cmpl(1'b1, 3'd0, 32'hDEAD); step();
        cmpl(1'b1, 3'd1, 32'hBEEF); step();
        cmpl(1'b0, '0, '0);
        step(); step();
        chk("x0_count", 32'(bus.count_o), 32'd0);
        chk("x0_empty", 32'(bus.empty_o), 32'd1);

        // Flush with completed non-head entries, then a stale completion
        for (int i = 0; i < 4; i++) begin
            alloc(1'b1, 5'(i + 16), 1'b1); step();
        end
        alloc(1'b0, 5'd0, 1'b0);
        cmpl(1'b1, 3'd3, 32'h3333); step();
        cmpl(1'b1, 3'd4, 32'h4444); step();
        cmpl(1'b0, '0, '0);
        bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
        chk("fl_count", 32'(bus.count_o), 32'd0);
        chk("fl_empty", 32'(bus.empty_o), 32'd1);
        chk("fl_tag", 32'(bus.alloc_tag_o), 32'd0);
        cmpl(1'b1, 3'd1, 32'hBAD); step();
        cmpl(1'b0, '0, '0);
        chk("stale_count", 32'(bus.count_o), 32'd0);
        alloc(1'b1, 5'd7, 1'b1); step();
        alloc(1'b1, 5'd9, 1'b1); step();
        alloc(1'b0, 5'd0, 1'b0);
        expect_wr(5'd7, 32'h70);
        cmpl(1'b1, 3'd0, 32'h70); step();
        cmpl(1'b0, '0, '0);
        step(); step();
        chk("stale_ignored", 32'(bus.count_o), 32'd1);

        // Allocate and commit at the same edge
        alloc(1'b1, 5'd10, 1'b1); step();
        alloc(1'b1, 5'd12, 1'b1); step();
        alloc(1'b0, 5'd0, 1'b0);
        expect_wr(5'd9, 32'h91);
        cmpl(1'b1, 3'd1, 32'h91); step();
        cmpl(1'b0, '0, '0);
        chk("sim_count_pre", 32'(bus.count_o), 32'd3);
        alloc(1'b1, 5'd11, 1'b1);
        chk("sim_tag_old_tail", 32'(bus.alloc_tag_o), 32'd4);
        step();
        alloc(1'b0, 5'd0, 1'b0);
        chk("sim_count_post", 32'(bus.count_o), 32'd3);
        chk("sim_wr_en", 32'(bus.wr_en_o), 32'd1);
        chk("sim_tag_next", 32'(bus.alloc_tag_o), 32'd5);

        // Asynchronous reset between edges with a done head entry
        cmpl(1'b1, 3'd2, 32'h5A); step();
        cmpl(1'b0, '0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(bus.wr_en_o), 32'd0);
        chk("arst_count", 32'(bus.count_o), 32'd0);
        chk("arst_empty", 32'(bus.empty_o), 32'd1);
        chk("arst_ready", 32'(bus.alloc_ready_o), 32'd1);
        chk("arst_tag", 32'(bus.alloc_tag_o), 32'd0);
        chk("arst_wr", {26'd0, bus.wr_en_o, bus.wr_addr_o}, 32'd0);
        chk("arst_wdata", bus.wr_data_o, 32'd0);
        step();
        chk("arst_no_write", 32'(bus.wr_en_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(); step(); step();
        chk("arst_discard", 32'(bus.count_o), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
